// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the Booth multiplier sequencer.
package mult_pkg;

  // Number of Booth iterations performed by the datapath.
  localparam int STEPS = 32;

  // Width of the step count bus; must hold values up to STEPS+1.
  localparam int CNT_W = 6;

  // Count value at which the datapath product is final and gets captured.
  localparam logic [CNT_W-1:0] CAPTURE_CNT = CNT_W'(STEPS + 1);

  // Two-state sequencer, single-bit encoding.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mult_step_counter.sv
// Step counter driving the datapath count bus, with terminal-count compare.
module mult_step_counter
  import mult_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             at_capture
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_capture;

  // Terminal compare: saturates the count so it can never wrap.
  always_comb begin
    w_at_capture = (r_count == CAPTURE_CNT);
  end

  // Counter register: clear wins, otherwise advance until the capture value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !w_at_capture) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count      = r_count;
  assign at_capture = w_at_capture;

endmodule

// File: rtl/mult_ctrl.sv
// Sequencer upstream of the radix-2 Booth multiplier datapath: latches
// operands, steps the datapath count, captures product and overflow.
module mult_ctrl
  import mult_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  output logic [31:0]      mult_a,
  output logic [31:0]      mult_b,
  output logic [CNT_W-1:0] mult_count,
  input  logic [31:0]      mult_result,
  input  logic             mult_overflow,
  output logic             busy,
  output logic             ready,
  output logic [31:0]      result,
  output logic             overflow
);

  state_t           r_state;
  state_t           w_state_next;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_result;
  logic             r_overflow;
  logic             r_ready;
  logic             w_accept;
  logic             w_capture;
  logic             w_busy;
  logic             w_cnt_clear;
  logic             w_cnt_en;
  logic             w_at_capture;
  logic [CNT_W-1:0] w_count;

  mult_step_counter u_step_counter (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (w_cnt_clear),
    .enable     (w_cnt_en),
    .count      (w_count),
    .at_capture (w_at_capture)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: start is only honoured in IDLE; RUN leaves at the capture count.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)        w_state_next = ST_RUN;
      ST_RUN:  if (w_at_capture) w_state_next = ST_IDLE;
      default:                   w_state_next = ST_IDLE;
    endcase
  end

  // Control decode from the current state.
  always_comb begin
    w_busy      = (r_state == ST_RUN);
    w_accept    = (r_state == ST_IDLE) && start;
    w_capture   = (r_state == ST_RUN) && w_at_capture;
    w_cnt_en    = (r_state == ST_RUN);
    w_cnt_clear = w_accept || w_capture;
  end

  // Operand/result registers; operands stay put after capture because the
  // datapath overflow logic keeps reading them combinationally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_ready <= w_capture;
      if (w_accept) begin
        r_a <= op_a;
        r_b <= op_b;
      end
      if (w_capture) begin
        r_result   <= mult_result;
        r_overflow <= mult_overflow;
      end
    end
  end

  assign mult_a     = r_a;
  assign mult_b     = r_b;
  assign mult_count = w_count;
  assign busy       = w_busy;
  assign ready      = r_ready;
  assign result     = r_result;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl with a behavioural stand-in for the Booth datapath.
module tb_mult_ctrl;
  import mult_pkg::*;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      op_a = '0;
  logic [31:0]      op_b = '0;
  logic [31:0]      mult_a;
  logic [31:0]      mult_b;
  logic [CNT_W-1:0] mult_count;
  logic [31:0]      mult_result;
  logic             mult_overflow;
  logic             busy;
  logic             ready;
  logic [31:0]      result;
  logic             overflow;

  int vectors = 0;
  int miscompares = 0;

  mult_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .op_a          (op_a),
    .op_b          (op_b),
    .mult_a        (mult_a),
    .mult_b        (mult_b),
    .mult_count    (mult_count),
    .mult_result   (mult_result),
    .mult_overflow (mult_overflow),
    .busy          (busy),
    .ready         (ready),
    .result        (result),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: loads on the count=0 edge, counts Booth steps on
  // counts 1..STEPS, and only shows the true product once all steps ran
  // and count STEPS+1 is presented. Otherwise it shows junk.
  logic signed [63:0] m_prod;
  int                 m_steps = 0;
  always @(posedge clk) begin
    if (mult_count == 0) begin
      m_prod  <= $signed(mult_a) * $signed(mult_b);
      m_steps <= 0;
    end else if (mult_count <= STEPS) begin
      m_steps <= m_steps + 1;
    end
  end
  logic m_ovf;
  assign m_ovf = !((&m_prod[63:31]) || !(|m_prod[63:31]));
  assign mult_result   = (m_steps == STEPS && mult_count == CAPTURE_CNT) ? m_prod[31:0] : 32'hDEAD_BEEF;
  assign mult_overflow = (m_steps == STEPS && mult_count == CAPTURE_CNT) ? m_ovf : 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for ready after an accepted start; returns edges since the start edge.
  task automatic wait_ready(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = busy ? 1 : 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (ready) begin
        edges = k;
        break;
      end
      if (busy) busy_cycles++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic exp_o);
    int edges, bc;
    op_a = a; op_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    wait_ready(edges, bc);
    chk({tag, "_latency"}, 64'(edges), 64'd34);
    chk({tag, "_result"}, 64'(result), 64'(exp_r));
    chk({tag, "_overflow"}, 64'(overflow), 64'(exp_o));
    $display("op %s: a=%h b=%h -> result=%h ovf=%0d after %0d edges", tag, a, b, result, overflow, edges);
    tick();
  endtask

  initial begin
    int edges, bc, rdy_seen, max_cnt;
    // Reset state
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_count", 64'(mult_count), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    #20 resetn = 1'b1;
    tick();

    // 3 x 5 with full timing checks
    op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy_after_start", 64'(busy), 64'd1);
    chk("t1_mult_a", 64'(mult_a), 64'd3);
    chk("t1_mult_b", 64'(mult_b), 64'd5);
    chk("t1_count0", 64'(mult_count), 64'd0);
    max_cnt = 0;
    edges = 0;
    bc = 1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (int'(mult_count) > max_cnt) max_cnt = int'(mult_count);
      if (k == 33) chk("t1_count33", 64'(mult_count), 64'd33);
      if (ready) begin
        edges = k;
        chk("t1_busy_in_ready", 64'(busy), 64'd0);
        break;
      end
      if (busy) bc++;
    end
    chk("t1_latency", 64'(edges), 64'd34);
    chk("t1_busy_cycles", 64'(bc), 64'd34);
    chk("t1_max_count", 64'(max_cnt), 64'd33);
    chk("t1_result", 64'(result), 64'd15);
    chk("t1_overflow", 64'(overflow), 64'd0);
    chk("t1_count_cleared", 64'(mult_count), 64'd0);
    $display("op 3x5: result=%h ovf=%0d after %0d edges, busy %0d cycles", result, overflow, edges, bc);
    tick();
    chk("t1_ready_one_cycle", 64'(ready), 64'd0);
    chk("t1_result_held", 64'(result), 64'd15);

    run_op("neg7x6", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0);
    run_op("ovf16", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    run_op("maxx2", 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);

    // Start while busy is ignored; start in ready cycle is accepted.
    op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_mult_a", 64'(mult_a), 64'd3);
    chk("ign_mult_b", 64'(mult_b), 64'd5);
    chk("ign_busy", 64'(busy), 64'd1);
    edges = 0;
    for (int k = 11; k <= 60; k++) begin
      tick();
      if (ready) begin edges = k; break; end
    end
    chk("ign_latency", 64'(edges), 64'd34);
    chk("ign_result", 64'(result), 64'd15);
    $display("ignored start: result=%h after %0d edges", result, edges);
    op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rdy_start_busy", 64'(busy), 64'd1);
    chk("rdy_start_ready", 64'(ready), 64'd0);
    chk("rdy_start_mult_a", 64'(mult_a), 64'd9);
    chk("rdy_start_result_kept", 64'(result), 64'd15);
    wait_ready(edges, bc);
    chk("rdy_start_latency", 64'(edges), 64'd34);
    chk("rdy_start_result", 64'(result), 64'd81);
    $display("ready-cycle start 9x9: result=%h after %0d edges", result, edges);
    tick();

    // Asynchronous abort mid-run.
    op_a = 32'd4; op_b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    #2 resetn = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_count", 64'(mult_count), 64'd0);
    chk("abort_mult_a", 64'(mult_a), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_ready", 64'(ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    rdy_seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ready) rdy_seen++;
    end
    chk("abort_no_ready", 64'(rdy_seen), 64'd0);
    $display("abort: ready pulses after reset = %0d", rdy_seen);

    run_op("2xneg2", 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
